// File: rtl/cvxif_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cvxif_issue_arbiter
// Function : Round-robin issue arbiter sharing one CVXIF coprocessor among
//            NUM_REQ requesters, with a slot table routing results back.
// Revision : 1.0 - initial release
// ============================================================================
module cvxif_issue_arbiter #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ID_WIDTH = 3,
  parameter int unsigned XLEN     = 64,
  localparam int unsigned SLOT_W  = $clog2(DEPTH),
  localparam int unsigned REQ_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_REQ-1:0]           req_issue_valid_i,
  output logic [NUM_REQ-1:0]           req_issue_ready_o,
  input  logic [NUM_REQ*32-1:0]        req_issue_instr_i,
  input  logic [NUM_REQ*ID_WIDTH-1:0]  req_issue_id_i,
  output logic                         req_issue_accept_o,
  output logic                         req_issue_writeback_o,
  input  logic [NUM_REQ-1:0]           req_flush_i,
  output logic [NUM_REQ-1:0]           req_result_valid_o,
  input  logic [NUM_REQ-1:0]           req_result_ready_i,
  output logic [ID_WIDTH-1:0]          req_result_id_o,
  output logic [XLEN-1:0]              req_result_data_o,
  output logic [4:0]                   req_result_rd_o,
  output logic                         req_result_we_o,
  output logic                         cop_issue_valid_o,
  input  logic                         cop_issue_ready_i,
  output logic [31:0]                  cop_issue_instr_o,
  output logic [SLOT_W-1:0]            cop_issue_id_o,
  input  logic                         cop_issue_accept_i,
  input  logic                         cop_issue_writeback_i,
  input  logic                         cop_result_valid_i,
  output logic                         cop_result_ready_o,
  input  logic [SLOT_W-1:0]            cop_result_id_i,
  input  logic [XLEN-1:0]              cop_result_data_i,
  input  logic [4:0]                   cop_result_rd_i,
  input  logic                         cop_result_we_i,
  output logic [SLOT_W:0]              occupancy_o
);

  // Slot table
  logic [DEPTH-1:0]    r_slot_valid;
  logic [REQ_W-1:0]    r_slot_owner [DEPTH];
  logic [ID_WIDTH-1:0] r_slot_id    [DEPTH];

  // Arbitration / lock state
  logic [REQ_W-1:0]    r_rr;
  logic                r_lock;
  logic [REQ_W-1:0]    r_grant;
  logic [SLOT_W-1:0]   r_lock_slot;

  logic [31:0]         w_instr_arr [NUM_REQ];
  logic [ID_WIDTH-1:0] w_id_arr    [NUM_REQ];

  logic [SLOT_W-1:0]   w_free_slot;
  logic                w_full;
  logic                w_arb_found;
  logic [REQ_W-1:0]    w_arb_idx;
  logic [REQ_W:0]      w_cand;
  logic [REQ_W-1:0]    w_grant;
  logic                w_issue_hs;
  logic                w_alloc;
  logic [ID_WIDTH-1:0] w_grant_id;
  logic [REQ_W-1:0]    w_res_owner;
  logic                w_res_live;
  logic                w_res_free;
  logic [SLOT_W:0]     w_occ;

  generate
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
      assign w_instr_arr[k]        = req_issue_instr_i[k*32 +: 32];
      assign w_id_arr[k]           = req_issue_id_i[k*ID_WIDTH +: ID_WIDTH];
      assign req_issue_ready_o[k]  = w_issue_hs && (w_grant == REQ_W'(k));
      assign req_result_valid_o[k] = w_res_live && cop_result_valid_i
                                     && (w_res_owner == REQ_W'(k));
    end
  endgenerate

  // Lowest-index free slot, from registered state only
  always_comb begin
    w_free_slot = '0;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      if (!r_slot_valid[s]) w_free_slot = SLOT_W'(s);
    end
  end

  assign w_full = &r_slot_valid;

  // Round-robin search starting at r_rr, wrapping past NUM_REQ-1
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    w_cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = {1'b0, r_rr} + (REQ_W+1)'(i);
      if (w_cand >= (REQ_W+1)'(NUM_REQ)) w_cand = w_cand - (REQ_W+1)'(NUM_REQ);
      if (!w_arb_found && req_issue_valid_i[w_cand[REQ_W-1:0]]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = w_cand[REQ_W-1:0];
      end
    end
  end

  // A locked issue keeps its grant and slot even if the table changes meanwhile
  assign w_grant           = r_lock ? r_grant : w_arb_idx;
  assign cop_issue_valid_o = r_lock || (w_arb_found && !w_full);
  assign cop_issue_id_o    = r_lock ? r_lock_slot : w_free_slot;
  assign cop_issue_instr_o = w_instr_arr[w_grant];
  assign w_grant_id        = w_id_arr[w_grant];

  assign w_issue_hs            = cop_issue_valid_o && cop_issue_ready_i;
  assign req_issue_accept_o    = cop_issue_accept_i;
  assign req_issue_writeback_o = cop_issue_writeback_i;
  assign w_alloc = w_issue_hs && cop_issue_accept_i && cop_issue_writeback_i
                   && !req_flush_i[w_grant];

  // Results for invalid or just-flushed slots are swallowed here
  assign w_res_owner        = r_slot_owner[cop_result_id_i];
  assign w_res_live         = r_slot_valid[cop_result_id_i] && !req_flush_i[w_res_owner];
  assign cop_result_ready_o = w_res_live ? req_result_ready_i[w_res_owner] : 1'b1;
  assign w_res_free         = cop_result_valid_i && cop_result_ready_o;

  assign req_result_id_o   = r_slot_id[cop_result_id_i];
  assign req_result_data_o = cop_result_data_i;
  assign req_result_rd_o   = cop_result_rd_i;
  assign req_result_we_o   = cop_result_we_i;

  always_comb begin
    w_occ = '0;
    for (int s = 0; s < DEPTH; s++) begin
      w_occ = w_occ + (SLOT_W+1)'(r_slot_valid[s]);
    end
  end

  assign occupancy_o = w_occ;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr         <= '0;
      r_lock       <= 1'b0;
      r_grant      <= '0;
      r_lock_slot  <= '0;
      r_slot_valid <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        r_slot_owner[s] <= '0;
        r_slot_id[s]    <= '0;
      end
    end else begin
      if (w_issue_hs) begin
        r_lock <= 1'b0;
        r_rr   <= (w_grant == REQ_W'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
      end else if (cop_issue_valid_o && !r_lock) begin
        r_lock      <= 1'b1;
        r_grant     <= w_grant;
        r_lock_slot <= w_free_slot;
      end
      // Clears first; an allocation only ever lands on a slot free at cycle start
      for (int s = 0; s < DEPTH; s++) begin
        if (r_slot_valid[s] && req_flush_i[r_slot_owner[s]]) r_slot_valid[s] <= 1'b0;
        if (w_res_free && (cop_result_id_i == SLOT_W'(s))) r_slot_valid[s] <= 1'b0;
        if (w_alloc && (cop_issue_id_o == SLOT_W'(s))) begin
          r_slot_valid[s] <= 1'b1;
          r_slot_owner[s] <= w_grant;
          r_slot_id[s]    <= w_grant_id;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cvxif_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cvxif_issue_arbiter
// Function : Directed, self-checking bench with a slot-table reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cvxif_issue_arbiter;

  localparam int N  = 2;
  localparam int D  = 4;
  localparam int IW = 3;
  localparam int XL = 64;
  localparam int SW = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_issue_valid;
  logic [N-1:0]    req_issue_ready;
  logic [N*32-1:0] req_issue_instr;
  logic [N*IW-1:0] req_issue_id;
  logic            req_issue_accept;
  logic            req_issue_writeback;
  logic [N-1:0]    req_flush;
  logic [N-1:0]    req_result_valid;
  logic [N-1:0]    req_result_ready;
  logic [IW-1:0]   req_result_id;
  logic [XL-1:0]   req_result_data;
  logic [4:0]      req_result_rd;
  logic            req_result_we;
  logic            cop_issue_valid;
  logic            cop_issue_ready;
  logic [31:0]     cop_issue_instr;
  logic [SW-1:0]   cop_issue_id;
  logic            cop_issue_accept;
  logic            cop_issue_writeback;
  logic            cop_result_valid;
  logic            cop_result_ready;
  logic [SW-1:0]   cop_result_id;
  logic [XL-1:0]   cop_result_data;
  logic [4:0]      cop_result_rd;
  logic            cop_result_we;
  logic [SW:0]     occupancy;

  int n_cmp = 0;
  int n_err = 0;

  cvxif_issue_arbiter dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .req_issue_valid_i     (req_issue_valid),
    .req_issue_ready_o     (req_issue_ready),
    .req_issue_instr_i     (req_issue_instr),
    .req_issue_id_i        (req_issue_id),
    .req_issue_accept_o    (req_issue_accept),
    .req_issue_writeback_o (req_issue_writeback),
    .req_flush_i           (req_flush),
    .req_result_valid_o    (req_result_valid),
    .req_result_ready_i    (req_result_ready),
    .req_result_id_o       (req_result_id),
    .req_result_data_o     (req_result_data),
    .req_result_rd_o       (req_result_rd),
    .req_result_we_o       (req_result_we),
    .cop_issue_valid_o     (cop_issue_valid),
    .cop_issue_ready_i     (cop_issue_ready),
    .cop_issue_instr_o     (cop_issue_instr),
    .cop_issue_id_o        (cop_issue_id),
    .cop_issue_accept_i    (cop_issue_accept),
    .cop_issue_writeback_i (cop_issue_writeback),
    .cop_result_valid_i    (cop_result_valid),
    .cop_result_ready_o    (cop_result_ready),
    .cop_result_id_i       (cop_result_id),
    .cop_result_data_i     (cop_result_data),
    .cop_result_rd_i       (cop_result_rd),
    .cop_result_we_i       (cop_result_we),
    .occupancy_o           (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a table of outstanding instructions plus the arbiter pointer
  bit          m_valid [D];
  int          m_owner [D];
  logic [IW-1:0] m_id  [D];
  int          m_rr;
  bit          m_lock;
  int          m_grant;
  int          m_lslot;

  typedef struct {
    logic          cvalid;
    int            grant;
    logic [SW-1:0] cid;
    logic [31:0]   instr;
    logic [N-1:0]  iready;
    logic [N-1:0]  rvalid;
    logic          rready;
    logic [IW-1:0] rid;
    logic [SW:0]   occ;
  } exp_t;

  function automatic exp_t model_eval();
    exp_t e;
    int   free_s;
    int   cnt;
    bit   found;
    int   s;
    int   o;
    free_s = -1;
    cnt    = 0;
    for (int i = 0; i < D; i++) begin
      if (!m_valid[i] && free_s < 0) free_s = i;
      if (m_valid[i]) cnt++;
    end
    e.occ    = (SW+1)'(cnt);
    e.cvalid = 1'b0;
    e.grant  = 0;
    e.cid    = '0;
    if (m_lock) begin
      e.cvalid = 1'b1;
      e.grant  = m_grant;
      e.cid    = SW'(m_lslot);
    end else begin
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!found && req_issue_valid[(m_rr + i) % N]) begin
          found   = 1'b1;
          e.grant = (m_rr + i) % N;
        end
      end
      e.cvalid = found && (free_s >= 0);
      e.cid    = (free_s >= 0) ? SW'(free_s) : '0;
    end
    e.instr  = req_issue_instr[e.grant*32 +: 32];
    e.iready = (e.cvalid && cop_issue_ready) ? N'(1 << e.grant) : '0;
    s = int'(cop_result_id);
    o = m_owner[s];
    if (m_valid[s] && !req_flush[o]) begin
      e.rvalid = cop_result_valid ? N'(1 << o) : '0;
      e.rready = req_result_ready[o];
      e.rid    = m_id[s];
    end else begin
      e.rvalid = '0;
      e.rready = 1'b1;
      e.rid    = '0;
    end
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < D; i++) begin
      m_valid[i] = 1'b0;
      m_owner[i] = 0;
      m_id[i]    = '0;
    end
    m_rr = 0; m_lock = 1'b0; m_grant = 0; m_lslot = 0;
  endtask

  // Compare on every falling edge, then advance the model to the next rising edge
  initial begin : compare_proc
    exp_t e;
    bit   hs;
    model_clear();
    forever begin
      @(negedge clk);
      if (!rst_n) model_clear();
      e = model_eval();
      chk("cop_issue_valid", 64'(cop_issue_valid), 64'(e.cvalid));
      if (e.cvalid) begin
        chk("cop_issue_instr", 64'(cop_issue_instr), 64'(e.instr));
        chk("cop_issue_id", 64'(cop_issue_id), 64'(e.cid));
      end
      chk("req_issue_ready", 64'(req_issue_ready), 64'(e.iready));
      chk("req_issue_accept", 64'(req_issue_accept), 64'(cop_issue_accept));
      chk("req_issue_writeback", 64'(req_issue_writeback), 64'(cop_issue_writeback));
      chk("req_result_valid", 64'(req_result_valid), 64'(e.rvalid));
      chk("cop_result_ready", 64'(cop_result_ready), 64'(e.rready));
      if (e.rvalid != '0) begin
        chk("req_result_id", 64'(req_result_id), 64'(e.rid));
        chk("req_result_data", req_result_data, cop_result_data);
        chk("req_result_rd", 64'(req_result_rd), 64'(cop_result_rd));
        chk("req_result_we", 64'(req_result_we), 64'(cop_result_we));
      end
      chk("occupancy", 64'(occupancy), 64'(e.occ));
      if (rst_n) begin
        hs = e.cvalid && cop_issue_ready;
        for (int i = 0; i < D; i++) begin
          if (m_valid[i] && req_flush[m_owner[i]]) m_valid[i] = 1'b0;
        end
        if (cop_result_valid && e.rready) m_valid[int'(cop_result_id)] = 1'b0;
        if (hs && cop_issue_accept && cop_issue_writeback && !req_flush[e.grant]) begin
          m_valid[int'(e.cid)] = 1'b1;
          m_owner[int'(e.cid)] = e.grant;
          m_id[int'(e.cid)]    = req_issue_id[e.grant*IW +: IW];
        end
        if (hs) begin
          m_lock = 1'b0;
          m_rr   = (e.grant + 1) % N;
        end else if (e.cvalid && !m_lock) begin
          m_lock  = 1'b1;
          m_grant = e.grant;
          m_lslot = int'(e.cid);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [31:0] instr, input logic [IW-1:0] id);
    req_issue_instr[k*32 +: 32] = instr;
    req_issue_id[k*IW +: IW]    = id;
  endtask

  task automatic set_res(input logic v, input logic [SW-1:0] slot);
    cop_result_valid = v;
    cop_result_id    = slot;
    cop_result_data  = 64'hD00D_0000_0000_0000 | 64'(slot);
    cop_result_rd    = 5'(slot) + 5'd1;
    cop_result_we    = 1'b1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [IW-1:0] t1_ids [4];

  initial begin : stimulus
    rst_n = 1'b0;
    req_issue_valid = '0; req_issue_instr = '0; req_issue_id = '0;
    req_flush = '0; req_result_ready = '1;
    cop_issue_ready = 1'b1; cop_issue_accept = 1'b1; cop_issue_writeback = 1'b1;
    set_res(1'b0, '0);
    tick(); tick();
    #1;
    chk("reset occupancy", 64'(occupancy), 64'd0);
    chk("reset cop_result_ready", 64'(cop_result_ready), 64'd1);
    chk("reset cop_issue_valid", 64'(cop_issue_valid), 64'd0);
    chk("reset req_result_valid", 64'(req_result_valid), 64'd0);
    rst_n = 1'b1;

    // 1: alternating grants fill slots 0..3, then results return to owners
    t1_ids[0] = 3'd0; t1_ids[1] = 3'd5; t1_ids[2] = 3'd2; t1_ids[3] = 3'd7;
    for (int i = 0; i < 4; i++) begin
      tick();
      req_issue_valid = 2'b11;
      set_req(0, 32'h100 + 32'(i), IW'(i));
      set_req(1, 32'h200 + 32'(i), IW'(i + 4));
      #1;
      chk("t1 grant", 64'(req_issue_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
      chk("t1 slot", 64'(cop_issue_id), 64'(i));
      chk("t1 instr", 64'(cop_issue_instr), ((i % 2 == 0) ? 64'h100 : 64'h200) + 64'(i));
    end
    tick(); #1;
    chk("t1 full valid", 64'(cop_issue_valid), 64'd0);
    chk("t1 full occ", 64'(occupancy), 64'd4);
    req_issue_valid = '0;
    for (int j = 0; j < 4; j++) begin
      tick();
      set_res(1'b1, SW'(j));
      #1;
      chk("t1 res owner", 64'(req_result_valid), (j % 2 == 0) ? 64'd1 : 64'd2);
      chk("t1 res id", 64'(req_result_id), 64'(t1_ids[j]));
    end
    tick(); set_res(1'b0, '0); #1;
    chk("t1 drained", 64'(occupancy), 64'd0);

    // 2: lock on requester 1 while requester 0 also requests
    tick();
    req_issue_valid = 2'b10; cop_issue_ready = 1'b0;
    set_req(1, 32'hBEEF_0001, 3'd6); set_req(0, 32'h0BAD_0000, 3'd1);
    #1;
    chk("t2 instr", 64'(cop_issue_instr), 64'hBEEF_0001);
    for (int c = 0; c < 2; c++) begin
      tick(); req_issue_valid = 2'b11; #1;
      chk("t2 held instr", 64'(cop_issue_instr), 64'hBEEF_0001);
      chk("t2 held slot", 64'(cop_issue_id), 64'd0);
    end
    tick(); cop_issue_ready = 1'b1; #1;
    chk("t2 hs ready", 64'(req_issue_ready), 64'd2);
    tick(); #1;
    chk("t2 next grant", 64'(req_issue_ready), 64'd1);
    chk("t2 next slot", 64'(cop_issue_id), 64'd1);
    tick(); req_issue_valid = '0; #1;
    chk("t2 occ", 64'(occupancy), 64'd2);
    set_res(1'b1, 2'd0); req_result_ready = 2'b01; #1;
    chk("t2 bp ready", 64'(cop_result_ready), 64'd0);
    chk("t2 bp id", 64'(req_result_id), 64'd6);
    tick(); req_result_ready = 2'b11;
    tick(); set_res(1'b1, 2'd1); #1;
    chk("t2 res1 owner", 64'(req_result_valid), 64'd1);
    tick(); set_res(1'b0, '0); #1;
    chk("t2 drained", 64'(occupancy), 64'd0);

    // 3: fill, stall while full, free slot 2 and see it reused
    for (int i = 0; i < 4; i++) begin
      tick(); req_issue_valid = 2'b01; set_req(0, 32'h300 + 32'(i), IW'(i)); #1;
      chk("t3 slot", 64'(cop_issue_id), 64'(i));
    end
    tick(); set_res(1'b1, 2'd2); #1;
    chk("t3 full valid", 64'(cop_issue_valid), 64'd0);
    chk("t3 full occ", 64'(occupancy), 64'd4);
    tick(); set_res(1'b0, '0); #1;
    chk("t3 reuse slot", 64'(cop_issue_id), 64'd2);
    chk("t3 reuse valid", 64'(cop_issue_valid), 64'd1);
    tick(); req_issue_valid = '0; req_flush = 2'b01; #1;
    chk("t3 refilled", 64'(occupancy), 64'd4);
    tick(); req_flush = '0; #1;
    chk("t3 flushed", 64'(occupancy), 64'd0);

    // 4: accepted without writeback allocates nothing
    tick(); req_issue_valid = 2'b10; cop_issue_writeback = 1'b0; set_req(1, 32'h4, 3'd4); #1;
    chk("t4 accept", 64'(req_issue_accept), 64'd1);
    chk("t4 ready", 64'(req_issue_ready), 64'd2);
    tick(); req_issue_valid = '0; cop_issue_writeback = 1'b1; #1;
    chk("t4 occ", 64'(occupancy), 64'd0);

    // 5: flush drops slots and their late results
    tick(); req_issue_valid = 2'b01; set_req(0, 32'h500, 3'd3); #1;
    chk("t5 slot0", 64'(cop_issue_id), 64'd0);
    tick(); set_req(0, 32'h501, 3'd4); #1;
    chk("t5 slot1", 64'(cop_issue_id), 64'd1);
    tick(); req_issue_valid = '0; req_flush = 2'b01; #1;
    chk("t5 occ before", 64'(occupancy), 64'd2);
    tick(); req_flush = '0; set_res(1'b1, 2'd1); req_result_ready = '0; #1;
    chk("t5 occ after", 64'(occupancy), 64'd0);
    chk("t5 dropped valid", 64'(req_result_valid), 64'd0);
    chk("t5 dropped ready", 64'(cop_result_ready), 64'd1);
    tick(); set_res(1'b0, '0); req_result_ready = '1;
    req_issue_valid = 2'b10; set_req(1, 32'h502, 3'd2); #1;
    chk("t5 req1 slot", 64'(cop_issue_id), 64'd0);
    tick(); req_issue_valid = '0; set_res(1'b1, 2'd0); req_flush = 2'b10; #1;
    chk("t5 same-cycle drop", 64'(req_result_valid), 64'd0);
    chk("t5 same-cycle ready", 64'(cop_result_ready), 64'd1);
    tick(); req_flush = '0; set_res(1'b0, '0); #1;
    chk("t5 final occ", 64'(occupancy), 64'd0);

    // 6: reset with three slots valid and a locked issue
    for (int i = 0; i < 3; i++) begin
      tick(); req_issue_valid = 2'b01; set_req(0, 32'h600 + 32'(i), IW'(i)); #1;
      chk("t6 slot", 64'(cop_issue_id), 64'(i));
    end
    tick(); req_issue_valid = 2'b10; cop_issue_ready = 1'b0; set_req(1, 32'h66, 3'd6); #1;
    chk("t6 lock slot", 64'(cop_issue_id), 64'd3);
    tick(); #1;
    chk("t6 occ", 64'(occupancy), 64'd3);
    rst_n = 1'b0; req_issue_valid = '0; #1;
    chk("t6 rst occ", 64'(occupancy), 64'd0);
    chk("t6 rst cop_valid", 64'(cop_issue_valid), 64'd0);
    chk("t6 rst res_ready", 64'(cop_result_ready), 64'd1);
    chk("t6 rst iready", 64'(req_issue_ready), 64'd0);
    tick(); rst_n = 1'b1; req_issue_valid = 2'b11; cop_issue_ready = 1'b1;
    set_req(0, 32'h77, 3'd1); #1;
    chk("t6 post grant", 64'(req_issue_ready), 64'd1);
    chk("t6 post slot", 64'(cop_issue_id), 64'd0);
    chk("t6 post instr", 64'(cop_issue_instr), 64'h77);
    tick(); req_issue_valid = '0; set_res(1'b1, 2'd2); #1;
    chk("t6 stale valid", 64'(req_result_valid), 64'd0);
    chk("t6 stale ready", 64'(cop_result_ready), 64'd1);
    tick(); set_res(1'b0, '0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cvxif_issue_arbiter.md
Name: cvxif_issue_arbiter

Overview:
Shares one CVXIF coprocessor between NumReq offloading requesters, such as multiple cva6 harts or a hart plus a debug/DII injector. Round-robin arbitration runs on the issue channel, with grant locking until the handshake completes. Each accepted writeback instruction gets an outstanding-slot entry, and the slot index is the downstream id. Results return to their owner via the slot table. A per-requester flush frees that requester's outstanding slots and drops their late results.

Parameters:
NumReq, 2, number of requesters (>=2).
Depth, 4, outstanding-slot table entries (power of 2, >=2); SlotW = $clog2(Depth).
IdWidth, 3, requester-side instruction id width.
XLEN, 64, result data width.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_issue_valid_i  in  NumReq  per-requester issue valid
req_issue_ready_o  out  NumReq  per-requester issue ready
req_issue_instr_i  in  NumReq*32  instruction, requester k at [k*32+:32]
req_issue_id_i  in  NumReq*IdWidth  requester-local id
req_issue_accept_o  out  1  coprocessor accept; valid with the ready of the granted requester
req_issue_writeback_o  out  1  coprocessor writeback flag; same qualification as accept
req_flush_i  in  NumReq  kill all outstanding instructions of requester k
req_result_valid_o  out  NumReq  result valid, one-hot to owner
req_result_ready_i  in  NumReq  owner result ready
req_result_id_o  out  IdWidth  owner's local id
req_result_data_o  out  XLEN  result data
req_result_rd_o  out  5  destination register
req_result_we_o  out  1  write enable
cop_issue_valid_o  out  1  to coprocessor
cop_issue_ready_i  in  1  from coprocessor
cop_issue_instr_o  out  32  granted instruction
cop_issue_id_o  out  SlotW  allocated slot index
cop_issue_accept_i  in  1  coprocessor will execute
cop_issue_writeback_i  in  1  coprocessor will produce a result
cop_result_valid_i  in  1  result valid
cop_result_ready_o  out  1  result ready
cop_result_id_i  in  SlotW  slot of result
cop_result_data_i  in  XLEN  data
cop_result_rd_i  in  5  rd
cop_result_we_i  in  1  we
occupancy_o  out  SlotW+1  number of valid slots

Behaviour:
- Reset values:
  - rr_q=0, lock_q=0, all slot valid bits 0, occupancy_o=0.
  - All valid/ready outputs 0, except cop_result_ready_o=1.
- Free slot: lowest-index invalid slot, computed from registered state only. full = all slots valid.
- Arbitration when not locked and not full:
  - grant = first k with req_issue_valid_i[k], searching from rr_q upward with wrap.
  - cop_issue_valid_o = any valid. instr is muxed from the granted requester; cop_issue_id_o = free slot.
- Lock:
  - If cop_issue_valid_o=1 and cop_issue_ready_i=0, set lock_q and hold the grant.
  - While locked, instr and id stay stable until the handshake, independent of other requesters.
- Handshake (cop valid & ready):
  - req_issue_ready_o[grant]=1, all others 0. Accept/writeback are passed through combinationally.
  - Clear lock_q; rr_q <= (grant+1) mod NumReq.
  - Allocate the slot {valid, owner=grant, local id} only if accept & writeback and req_flush_i[grant]=0.
- Full: cop_issue_valid_o=0 and all req_issue_ready_o=0. A slot freed this cycle is usable next cycle (1-cycle bubble).
- Result routing, slot s = cop_result_id_i:
  - If slot s is valid and owner o is not flushed this cycle: req_result_valid_o[o] = cop_result_valid_i, cop_result_ready_o = req_result_ready_i[o], and the id comes from the table. On handshake, slot s frees.
  - Otherwise (invalid slot, or owner flushed this cycle): the result is dropped. cop_result_ready_o=1, no req_result_valid_o, and slot s frees.
- Flush:
  - req_flush_i[k] invalidates every slot with owner k at the clock edge.
  - It does not cancel a locked issue. The handshake completes normally but allocates no slot.
- Simultaneous events: a result free, a flush and an allocation in the same cycle all apply. An allocation never targets a slot valid at the cycle start.
- occupancy_o = popcount of slot valid bits (registered state).
- Combinational paths: all outputs are combinational from registered state plus inputs; there are no added pipeline stages. Reset mid-operation clears all state; in-flight results are afterwards dropped as invalid-slot results.

Test Plan:
1. Req0 and req1 issue continuously, coprocessor always ready/accept/writeback, results returned immediately -> grants alternate 0,1,0,1; cop_issue_id_o = 0,1,2,3 until results free slots; each result reaches the correct owner with its original local id.
2. Req1 valid with cop_issue_ready_i held 0 for 3 cycles while req0 asserts valid -> grant stays 1 with instr/id stable; after the handshake rr_q=0 and req0 is granted next.
3. Four accepted writeback instructions with no results -> occupancy_o=4 and cop_issue_valid_o=0; a result for slot 2 -> slot 2 reallocated on the next cycle's issue.
4. Issue accepted with accept=1, writeback=0 -> no slot allocated, occupancy unchanged, req_issue_accept_o=1 seen by the requester.
5. Req0 owns slots 0 and 1, req_flush_i[0] pulsed, then a result arrives for slot 1 -> occupancy drops by 2; result dropped with cop_result_ready_o=1; req_result_valid_o=0.
6. Reset asserted with 3 slots valid and lock set -> all outputs at reset values immediately; the first post-reset issue gets slot 0 with grant searched from requester 0.
